dma_frame_packer: RTL and testbench

//  Sequences video frames into the 256-bit Avalon-ST sink of dma_write_master_1.

---
 rtl/dma_frame_packer.sv | 214 +++++++++++++++++++++
 tb/tb_dma_frame_packer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_frame_packer.sv
// Packs 32-bit pixels into 8-lane 256-bit Avalon-ST beats, framing each video frame
// with SOP/EOP/EMPTY, aligning to the source start-of-frame and counting frames.
module dma_frame_packer #(
    parameter int unsigned PIX_W  = 32,
    parameter int unsigned BEAT_W = 8 * PIX_W,
    parameter int unsigned LEN_W  = 24
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [LEN_W-1:0]  cfg_frame_len,
    input  logic              cfg_continuous,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic              pix_ready,
    output logic [BEAT_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop,
    output logic [4:0]        src_empty,
    output logic              busy,
    output logic              done,
    output logic              err_sof,
    output logic [15:0]       frames_done
);

    localparam int unsigned Lanes = 8;

    typedef enum logic [1:0] {StIdle, StWaitSof, StPack, StDrain} state_e;

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  acc_q, acc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               acc_full_q, acc_full_d;
    logic               acc_eop_q, acc_eop_d;
    logic               acc_sop_q, acc_sop_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               err_sof_q, err_sof_d;
    logic [BEAT_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_sop_q, out_sop_d;
    logic               out_eop_q, out_eop_d;
    logic [4:0]         out_empty_q, out_empty_d;
    logic               done_q, done_d;
    logic [15:0]        frames_q, frames_d;
    logic [3:0]         free_lanes;
    logic               load;
    logic               eop_fire;

    // The output register takes the accumulator whenever it is empty or being drained.
    assign load       = acc_full_q && (!out_valid_q || src_ready);
    assign eop_fire   = out_valid_q && src_ready && out_eop_q;
    assign free_lanes = 4'd8 - cnt_q;

    assign src_data    = out_data_q;
    assign src_valid   = out_valid_q;
    assign src_sop     = out_sop_q;
    assign src_eop     = out_eop_q;
    assign src_empty   = out_empty_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign err_sof     = err_sof_q;
    assign frames_done = frames_q;

    // Pixel intake: open while hunting SOF; in PACK only when the accumulator has room,
    // counting the cycle it is being emptied so full-rate streaming is possible.
    always_comb begin
        pix_ready = 1'b0;
        unique case (state_q)
            StWaitSof: pix_ready = 1'b1;
            StPack:    pix_ready = !acc_full_q || load;
            default:   pix_ready = 1'b0;
        endcase
    end

    // Next state for the frame FSM and the pixel accumulator.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        acc_full_d = acc_full_q;
        acc_eop_d  = acc_eop_q;
        acc_sop_d  = acc_sop_q;
        len_d      = len_q;
        rem_d      = rem_q;
        err_sof_d  = err_sof_q;

        if (load) begin
            acc_d      = '0;
            cnt_d      = '0;
            acc_full_d = 1'b0;
            acc_eop_d  = 1'b0;
            acc_sop_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (cfg_start && !cfg_abort && cfg_frame_len != '0) begin
                    len_d     = cfg_frame_len;
                    err_sof_d = 1'b0;
                    state_d   = StWaitSof;
                end
            end
            StWaitSof: begin
                if (cfg_abort) begin
                    state_d = StIdle;
                end else if (pix_valid && pix_sof) begin
                    acc_d[PIX_W-1:0] = pix_data;
                    cnt_d            = 4'd1;
                    acc_sop_d        = 1'b1;
                    rem_d            = len_q - LEN_W'(1);
                    if (len_q == LEN_W'(1)) begin
                        acc_full_d = 1'b1;
                        acc_eop_d  = 1'b1;
                        state_d    = StDrain;
                    end else begin
                        state_d = StPack;
                    end
                end
            end
            StPack: begin
                if (pix_valid && pix_ready) begin
                    for (int unsigned k = 0; k < Lanes; k++) begin
                        if (cnt_d == 4'(k)) acc_d[k*PIX_W +: PIX_W] = pix_data;
                    end
                    cnt_d = cnt_d + 4'd1;
                    rem_d = rem_q - LEN_W'(1);
                    if (pix_sof) err_sof_d = 1'b1;
                    if (cnt_d == 4'd8) acc_full_d = 1'b1;
                    // Last pixel wins over a coincident abort; both just close the frame.
                    if (rem_q == LEN_W'(1) || cfg_abort) begin
                        acc_full_d = 1'b1;
                        acc_eop_d  = 1'b1;
                        state_d    = StDrain;
                    end
                end else if (cfg_abort) begin
                    // An empty accumulator gets one zero pixel so the frame still ends on EOP.
                    if (cnt_d == 4'd0) cnt_d = 4'd1;
                    acc_full_d = 1'b1;
                    acc_eop_d  = 1'b1;
                    state_d    = StDrain;
                end
            end
            StDrain: begin
                if (eop_fire) state_d = cfg_continuous ? StWaitSof : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output beat register, completion pulse and frame counter.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_empty_d = out_empty_q;
        if (load) begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
            out_sop_d   = acc_sop_q;
            out_eop_d   = acc_eop_q;
            out_empty_d = acc_eop_q ? {free_lanes[2:0], 2'b00} : 5'd0;
        end else if (src_ready) begin
            out_valid_d = 1'b0;
        end
        done_d   = eop_fire;
        frames_d = eop_fire ? frames_q + 16'd1 : frames_q;
    end

    // State registers; reset discards any frame in flight.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_full_q  <= 1'b0;
            acc_eop_q   <= 1'b0;
            acc_sop_q   <= 1'b0;
            len_q       <= '0;
            rem_q       <= '0;
            err_sof_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            done_q      <= 1'b0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_full_q  <= acc_full_d;
            acc_eop_q   <= acc_eop_d;
            acc_sop_q   <= acc_sop_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            err_sof_q   <= err_sof_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_empty_q <= out_empty_d;
            done_q      <= done_d;
            frames_q    <= frames_d;
        end
    end

endmodule

// File: tb/tb_dma_frame_packer.sv
// Randomized bench for dma_frame_packer: a pixel-queue driver, a beat scoreboard built
// from frame contents, and directed abort / reset / error scenarios.
module tb_dma_frame_packer;

    localparam int PW = 32;
    localparam int BW = 256;
    localparam int LW = 24;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n = 1'b0;
    logic [LW-1:0] cfg_frame_len = '0;
    logic          cfg_continuous = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_abort = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic          pix_ready;
    logic [BW-1:0] src_data;
    logic          src_valid;
    logic          src_ready = 1'b1;
    logic          src_sop;
    logic          src_eop;
    logic [4:0]    src_empty;
    logic          busy;
    logic          done;
    logic          err_sof;
    logic [15:0]   frames_done;

    dma_frame_packer dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .cfg_frame_len  (cfg_frame_len),
        .cfg_continuous (cfg_continuous),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_sof        (pix_sof),
        .pix_ready      (pix_ready),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_sop        (src_sop),
        .src_eop        (src_eop),
        .src_empty      (src_empty),
        .busy           (busy),
        .done           (done),
        .err_sof        (err_sof),
        .frames_done    (frames_done)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct packed {
        logic [BW-1:0] data;
        logic          sop;
        logic          eop;
        logic [4:0]    empty;
    } beat_t;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          sof;
    } pix_t;

    beat_t         exp_q[$];
    pix_t          drv_q[$];
    int            total = 0;
    int            bad = 0;
    int            n_acc = 0;
    int            n_done = 0;
    int            exp_frames = 0;
    bit            pix_acc = 1'b0;
    bit            prev_hold = 1'b0;
    logic [BW-1:0] prev_data = '0;
    bit            stall = 1'b0;
    bit            rnd_rdy = 1'b0;
    bit            bubbles = 1'b0;

    task automatic check_eq(input string tag, input logic [BW-1:0] got,
                            input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Pixel driver and sink-ready generator, acting just after each rising edge.
    always @(posedge clk_clk) begin
        bit hold;
        #1;
        hold = pix_valid && !pix_acc;
        if (pix_acc && drv_q.size() != 0) drv_q.delete(0);
        if (drv_q.size() != 0 && (hold || !bubbles || $urandom_range(3) != 0)) begin
            pix_valid = 1'b1;
            pix_data  = drv_q[0].data;
            pix_sof   = drv_q[0].sof;
        end else begin
            pix_valid = 1'b0;
            pix_data  = '0;
            pix_sof   = 1'b0;
        end
        src_ready = stall ? 1'b0 : (rnd_rdy ? ($urandom_range(2) != 0) : 1'b1);
    end

    // Monitor on the falling edge: handshakes, scoreboard, hold stability, done pulses.
    always @(negedge clk_clk) begin
        beat_t b;
        if (!reset_reset_n) begin
            pix_acc   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            pix_acc = pix_valid && pix_ready;
            if (pix_acc) n_acc++;
            if (prev_hold) begin
                check_eq("hold_valid", BW'(src_valid), BW'(1));
                check_eq("hold_data", src_data, prev_data);
            end
            if (src_valid && src_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", BW'(src_valid), '0);
                end else begin
                    b = exp_q.pop_front();
                    check_eq("beat_data", src_data, b.data);
                    check_eq("beat_sop", BW'(src_sop), BW'(b.sop));
                    check_eq("beat_eop", BW'(src_eop), BW'(b.eop));
                    check_eq("beat_empty", BW'(src_empty), BW'(b.empty));
                end
            end
            prev_hold = src_valid && !src_ready;
            prev_data = src_data;
            if (done) n_done++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk_clk);
            #2;
        end
    endtask

    task automatic start(input int len, input bit cont);
        cfg_frame_len  = LW'(len);
        cfg_continuous = cont;
        cfg_start      = 1'b1;
        cyc(1);
        cfg_start      = 1'b0;
    endtask

    task automatic abort_pulse();
        cfg_abort = 1'b1;
        cyc(1);
        cfg_abort = 1'b0;
    endtask

    task automatic push_pix(input logic [PW-1:0] d, input bit sof);
        pix_t p;
        p.data = d;
        p.sof  = sof;
        drv_q.push_back(p);
    endtask

    // Queue junk + one frame and derive its beats from the frame contents alone.
    task automatic push_frame(input int len, input int junk, input int mid_sof, input int base);
        logic [PW-1:0] f[$];
        logic [PW-1:0] d;
        beat_t b;
        int nb;
        int n;
        for (int i = 0; i < junk; i++) push_pix($urandom, 1'b0);
        for (int i = 0; i < len; i++) begin
            d = (base >= 0) ? PW'(base + i) : $urandom;
            f.push_back(d);
            push_pix(d, (i == 0) || (i == mid_sof));
        end
        nb = (len + 7) / 8;
        for (int bi = 0; bi < nb; bi++) begin
            b = '0;
            for (int k = 0; k < 8; k++) begin
                if (bi * 8 + k < len) b.data[k*PW +: PW] = f[bi*8+k];
            end
            n = len - bi * 8;
            if (n > 8) n = 8;
            b.sop   = (bi == 0);
            b.eop   = (bi == nb - 1);
            b.empty = b.eop ? 5'((8 - n) * 4) : 5'd0;
            exp_q.push_back(b);
        end
        exp_frames++;
    endtask

    task automatic wait_fed(input int budget);
        int c = 0;
        while (drv_q.size() != 0 && c < budget) begin
            cyc(1);
            c++;
        end
        if (drv_q.size() != 0) begin
            check_eq("feed_timeout", BW'(drv_q.size()), '0);
            drv_q.delete();
        end
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || drv_q.size() != 0) && c < budget) begin
            cyc(1);
            c++;
        end
        if (exp_q.size() != 0 || drv_q.size() != 0) begin
            check_eq("drain_timeout", BW'(exp_q.size() + drv_q.size()), '0);
            exp_q.delete();
            drv_q.delete();
        end
        cyc(3);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, BW'(src_valid), '0);
        check_eq({tag, "_data"}, src_data, '0);
        check_eq({tag, "_sopeop"}, BW'({src_sop, src_eop, src_empty}), '0);
        check_eq({tag, "_busy"}, BW'(busy), '0);
        check_eq({tag, "_done"}, BW'(done), '0);
        check_eq({tag, "_err"}, BW'(err_sof), '0);
        check_eq({tag, "_frames"}, BW'(frames_done), '0);
        check_eq({tag, "_pixrdy"}, BW'(pix_ready), '0);
    endtask

    initial begin
        int d0;
        int a0;
        int len;
        beat_t b;

        cyc(3);
        check_all_zero("reset");
        reset_reset_n = 1'b1;
        cyc(2);

        // Basic 2-beat frame, then a partial final beat with a start-while-busy attempt.
        d0 = n_done;
        start(16, 1'b0);
        push_frame(16, 0, -1, 0);
        wait_drain(2000);
        check_eq("t1_done", BW'(n_done - d0), BW'(1));
        check_eq("t1_frames", BW'(frames_done), BW'(exp_frames));
        check_eq("t1_idle", BW'(busy), '0);
        check_eq("t1_err", BW'(err_sof), '0);

        start(10, 1'b0);
        push_frame(10, 0, -1, 0);
        cyc(3);
        start(3, 1'b0);
        wait_drain(2000);
        check_eq("t2_frames", BW'(frames_done), BW'(exp_frames));

        // Pixels ahead of SOF are dropped.
        start(8, 1'b0);
        push_frame(8, 3, -1, 'hA);
        wait_drain(2000);
        check_eq("t4_idle", BW'(busy), '0);

        // Sink stalled: intake must stop after two beats' worth of pixels.
        stall = 1'b1;
        a0 = n_acc;
        start(32, 1'b0);
        push_frame(32, 0, -1, -1);
        cyc(30);
        check_eq("t3_accepted", BW'(n_acc - a0), BW'(16));
        check_eq("t3_pixrdy", BW'(pix_ready), '0);
        check_eq("t3_valid", BW'(src_valid), BW'(1));
        stall = 1'b0;
        wait_drain(2000);
        check_eq("t3_frames", BW'(frames_done), BW'(exp_frames));

        // Abort after 3 pixels: one short EOP beat.
        d0 = n_done;
        start(100, 1'b0);
        for (int i = 0; i < 3; i++) push_pix(PW'(32'h100 + i), i == 0);
        b = '0;
        for (int i = 0; i < 3; i++) b.data[i*PW +: PW] = PW'(32'h100 + i);
        b.sop = 1'b1;
        b.eop = 1'b1;
        b.empty = 5'd20;
        exp_q.push_back(b);
        exp_frames++;
        wait_fed(500);
        cyc(2);
        abort_pulse();
        wait_drain(500);
        check_eq("t5_done", BW'(n_done - d0), BW'(1));
        check_eq("t5_idle", BW'(busy), '0);

        // Abort with an empty accumulator after one full beat: zero dummy EOP beat.
        start(100, 1'b0);
        push_frame(8, 0, -1, 'h200);
        exp_q[exp_q.size()-1].eop = 1'b0;
        b = '0;
        b.eop = 1'b1;
        b.empty = 5'd28;
        exp_q.push_back(b);
        wait_fed(500);
        cyc(4);
        abort_pulse();
        wait_drain(500);
        check_eq("t5b_frames", BW'(frames_done), BW'(exp_frames));
        check_eq("t5b_idle", BW'(busy), '0);

        // Abort while hunting SOF, start+abort together, and zero length: no activity.
        start(16, 1'b0);
        cyc(2);
        check_eq("wsof_busy", BW'(busy), BW'(1));
        abort_pulse();
        cyc(1);
        check_eq("wsof_abort", BW'(busy), '0);
        cfg_abort = 1'b1;
        start(16, 1'b0);
        cfg_abort = 1'b0;
        cyc(1);
        check_eq("start_abort", BW'(busy), '0);
        start(0, 1'b0);
        cyc(1);
        check_eq("len_zero", BW'(busy), '0);

        // SOF inside a frame flags err_sof but keeps the data; next start clears it.
        start(16, 1'b0);
        push_frame(16, 0, 5, -1);
        wait_drain(2000);
        check_eq("t6_err", BW'(err_sof), BW'(1));
        start(8, 1'b0);
        check_eq("t6_errclr", BW'(err_sof), '0);
        push_frame(8, 0, -1, -1);
        wait_drain(2000);

        // Randomized continuous runs with bubbles and sink backpressure.
        rnd_rdy = 1'b1;
        bubbles = 1'b1;
        for (int it = 0; it < 3; it++) begin
            len = (it == 0) ? 1 : (it == 1) ? 8 : int'($urandom_range(2, 40));
            d0 = n_done;
            start(len, 1'b1);
            for (int f = 0; f < 4; f++) push_frame(len, int'($urandom_range(0, 3)), -1, -1);
            wait_drain(4000);
            check_eq("rnd_done", BW'(n_done - d0), BW'(4));
            check_eq("rnd_frames", BW'(frames_done), BW'(exp_frames));
            check_eq("rnd_rearmed", BW'(busy), BW'(1));
            abort_pulse();
            cyc(1);
            check_eq("rnd_idle", BW'(busy), '0);
        end
        rnd_rdy = 1'b0;
        bubbles = 1'b0;

        // Reset mid-frame clears everything at once; continuous mode then re-arms.
        start(32, 1'b0);
        push_frame(32, 0, -1, -1);
        cyc(12);
        reset_reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        drv_q.delete();
        exp_q.delete();
        exp_frames = 0;
        cyc(2);
        reset_reset_n = 1'b1;
        cyc(2);
        d0 = n_done;
        start(5, 1'b1);
        push_frame(5, 0, -1, -1);
        push_frame(5, 2, -1, -1);
        wait_drain(2000);
        check_eq("cont_done", BW'(n_done - d0), BW'(2));
        check_eq("cont_frames", BW'(frames_done), BW'(exp_frames));
        check_eq("cont_busy", BW'(busy), BW'(1));
        abort_pulse();
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
